// File: rtl/wrr_arbiter_core.sv
// Weighted round-robin arbiter core.
// A single FSM (ARB/SERVE) plus a per-slice credit counter replaces separate
// grant/weight/count load sequencing. Each requester owns a programmable
// weight; the winner holds the grant for up to weight cycles, then priority
// rotates to the index after the winner.
module wrr_arbiter_core #(
  parameter int unsigned N  = 8,
  parameter int unsigned WW = 4,
  parameter int unsigned IW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  request,
  input  logic          enable,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [WW-1:0] cfg_weight,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx,
  output logic          burst_done,
  output logic          busy
);

  typedef enum logic [0:0] {StArb, StServe} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] weight_q [N];
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] count_q, count_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_idx_q, grant_idx_d;
  logic          burst_done_q, burst_done_d;

  logic [N-1:0]  eligible;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic          slice_end;

  // Requesters with a zero weight are masked out of arbitration.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N; i++) begin
      eligible[i] = request[i] && (weight_q[i] != '0);
    end
  end

  // Rotating priority search starting at ptr; IW-bit addition wraps modulo N.
  always_comb begin
    logic [IW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr_q + IW'(k);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Slice ends on the last credit or as soon as the winner releases its request.
  assign slice_end = (count_q == WW'(1)) || !request[grant_idx_q];

  // Weight table: writable in any state; a running slice keeps its loaded count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        weight_q[i] <= WW'(1);
      end
    end else if (cfg_we) begin
      weight_q[cfg_idx] <= cfg_weight;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StArb;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; enable only gates the start of a new slice.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StArb:   if (enable && win_found) state_d = StServe;
      StServe: if (slice_end) state_d = StArb;
      default: state_d = StArb;
    endcase
  end

  // Output and datapath next-state logic (grant, credit counter, pointer).
  always_comb begin
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    burst_done_d  = 1'b0;
    count_d       = count_q;
    ptr_d         = ptr_q;
    unique case (state_q)
      StArb: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        if (enable && win_found) begin
          grant_d[win_idx] = 1'b1;
          grant_valid_d    = 1'b1;
          grant_idx_d      = win_idx;
          count_d          = weight_q[win_idx];
        end
      end
      StServe: begin
        if (slice_end) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          burst_done_d  = 1'b1;
          ptr_d         = grant_idx_q + IW'(1);
        end else begin
          count_d = count_q - WW'(1);
        end
      end
      default: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath state; reset aborts any running slice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      burst_done_q  <= 1'b0;
      count_q       <= '0;
      ptr_q         <= '0;
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      burst_done_q  <= burst_done_d;
      count_q       <= count_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign burst_done  = burst_done_q;
  assign busy        = (state_q == StServe);

endmodule

// File: tb/tb_wrr_arbiter_core.sv
// Bench for wrr_arbiter_core: directed stimulus pushes expected slices
// (winner, length, idle gap before it) into a queue; a monitor rebuilds each
// slice from the DUT outputs and checks it when burst_done pulses.
module tb_wrr_arbiter_core;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] request;
  logic       enable;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic [3:0] cfg_weight;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_idx;
  logic       burst_done;
  logic       busy;

  typedef struct {
    int idx;
    int len;
    int gap;  // -1 = do not check
  } slice_t;

  slice_t exp_q[$];
  slice_t e;

  int n_checks    = 0;
  int n_fail      = 0;
  int slices_seen = 0;
  int target      = 0;

  // Monitor state
  bit in_slice = 1'b0;
  int cur_idx  = 0;
  int cur_len  = 0;
  int cur_gap  = 0;
  int idle     = 0;

  logic [7:0] t1_grant [8] = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h01, 8'h00, 8'h04, 8'h00};
  logic       t1_bd    [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  wrr_arbiter_core #(.N(8), .WW(4), .IW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .enable     (enable),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .burst_done (burst_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int idx, input int len, input int gap);
    slice_t s;
    s.idx = idx;
    s.len = len;
    s.gap = gap;
    exp_q.push_back(s);
  endtask

  task automatic cfg_write(input int idx, input int w);
    cfg_we     = 1'b1;
    cfg_idx    = 3'(idx);
    cfg_weight = 4'(w);
    step();
    cfg_we     = 1'b0;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!grant_valid && n < 50) begin
      step();
      n++;
    end
    if (!grant_valid) chk(name, 0, 1);
  endtask

  task automatic wait_slices(input string name);
    int n = 0;
    while (slices_seen < target && n < 200) begin
      step();
      n++;
    end
    if (slices_seen < target) chk(name, slices_seen, target);
  endtask

  // Monitor: reconstructs slices from outputs and scores them against exp_q.
  always @(negedge clk) begin
    if (!reset) begin
      in_slice = 1'b0;
      idle     = 0;
    end else begin
      if (burst_done) begin
        chk("bd_with_valid", int'(grant_valid), 0);
        if (!in_slice || exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_slice: got idx %0d len %0d required none (t=%0t)",
                   cur_idx, cur_len, $time);
        end else begin
          e = exp_q.pop_front();
          chk("slice_idx", cur_idx, e.idx);
          chk("slice_len", cur_len, e.len);
          if (e.gap >= 0) chk("slice_gap", cur_gap, e.gap);
        end
        in_slice = 1'b0;
        slices_seen++;
        idle = 0;
      end
      if (grant_valid) begin
        if (!in_slice) begin
          in_slice = 1'b1;
          cur_idx  = int'(grant_idx);
          cur_len  = 0;
          cur_gap  = idle;
        end
        cur_len++;
        chk("grant_onehot", int'(grant), 1 << cur_idx);
        chk("grant_idx_hold", int'(grant_idx), cur_idx);
        chk("busy_in_slice", int'(busy), 1);
      end else begin
        idle++;
      end
    end
  end

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    cfg_we     = 1'b0;
    cfg_idx    = '0;
    cfg_weight = '0;
    request    = '0;
    repeat (3) step();
    chk("rst_grant", int'(grant), 0);
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_idx", int'(grant_idx), 0);
    chk("rst_bd", int'(burst_done), 0);
    chk("rst_busy", int'(busy), 0);

    // 1: default weights, requesters 0 and 2 alternate with period 4
    request = 8'b0000_0101;
    push(0, 1, -1); push(2, 1, 1); push(0, 1, 1); push(2, 1, 1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t1_grant", int'(grant), int'(t1_grant[i]));
      chk("t1_bd", int'(burst_done), int'(t1_bd[i]));
    end
    target = 4;
    wait_slices("t1_timeout");
    request = '0;

    // 2: weights 3 and 2, period 7; ptr=3 so requester 0 wins first
    cfg_write(0, 3);
    cfg_write(1, 2);
    request = 8'b0000_0011;
    push(0, 3, -1); push(1, 2, 1); push(0, 3, 1); push(1, 2, 1);
    target += 4;
    wait_slices("t2_timeout");
    request = '0;

    // 3: zero weight masks requester 5 until reprogrammed
    cfg_write(5, 0);
    request = 8'b0010_0000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_masked_valid", int'(grant_valid), 0);
      chk("t3_masked_busy", int'(busy), 0);
    end
    push(5, 2, -1);
    cfg_write(5, 2);
    target += 1;
    wait_slices("t3_timeout");
    request = '0;

    // 4: early release after 3 granted cycles, then ptr=4 favours 4 over 3
    cfg_write(3, 8);
    request = 8'b0000_1000;
    push(3, 3, -1);
    wait_grant("t4_grant_timeout");
    step();
    step();
    request = '0;
    target += 1;
    wait_slices("t4_timeout");
    push(4, 1, -1);
    request = 8'b0001_1000;
    target += 1;
    wait_slices("t4b_timeout");
    request = '0;

    // 5: asynchronous reset mid-slice, then ptr and weights back to defaults
    cfg_write(6, 6);
    request = 8'b0100_0000;
    wait_grant("t5_grant_timeout");
    step();
    #1 reset = 1'b0;
    #1;
    chk("t5_async_grant", int'(grant), 0);
    chk("t5_async_valid", int'(grant_valid), 0);
    chk("t5_async_bd", int'(burst_done), 0);
    chk("t5_async_busy", int'(busy), 0);
    step();
    step();
    request = 8'b0100_0001;
    push(0, 1, -1); push(6, 1, 1);
    reset = 1'b1;
    target += 2;
    wait_slices("t5_timeout");
    request = '0;

    // 6: enable low mid-slice does not shorten it but blocks the next grant
    cfg_write(2, 4);
    request = 8'b0000_1100;
    push(2, 4, -1);
    wait_grant("t6_grant_timeout");
    enable = 1'b0;
    target += 1;
    wait_slices("t6_timeout");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_stall_valid", int'(grant_valid), 0);
      chk("t6_stall_busy", int'(busy), 0);
    end
    push(3, 1, -1);
    enable = 1'b1;
    target += 1;
    wait_slices("t6b_timeout");
    request = '0;

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter_core.md
Name: wrr_arbiter_core

Overview:
- Self-contained weighted round-robin arbiter for 8 requesters sharing one resource.
- Holds a programmable weight per requester and grants the winner for a slice of up to weight cycles.
- After each slice, rotates priority to the requester after the winner.
- Sits between requester request lines and the shared datapath. Replaces the separate grant/weight/count load sequencing with one FSM plus credit counter.

Parameters:
N, 8, number of requesters (power of two, 2..16)
WW, 4, weight and slice-counter width in bits
IW, 3, index width, equals log2(N)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
request  input  N  per-requester request level, sampled on clk
enable  input  1  1 = new slices may start; 0 = finish current slice, then stall
cfg_we  input  1  weight write strobe
cfg_idx  input  IW  requester index for weight write
cfg_weight  input  WW  weight value; 0 masks the requester
grant  output  N  one-hot grant, registered
grant_valid  output  1  OR of grant, registered
grant_idx  output  IW  binary index of current or last winner, registered
burst_done  output  1  one-cycle pulse on the cycle after a slice ends
busy  output  1  1 while state = SERVE

Behaviour:
- Reset (async, reset=0) sets: grant=0, grant_valid=0, grant_idx=0, burst_done=0, busy=0, state=ARB, ptr=0, count=0, all weights=1. Reset mid-slice aborts the slice immediately; no burst_done is generated.
- eligible[i] = request[i] AND (weight[i] != 0).
- Winner: first eligible index searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N).
- FSM has two states, ARB and SERVE.
- ARB, when enable=1 and any eligible is set, on the next edge:
  - grant = onehot(winner), grant_valid=1, grant_idx=winner;
  - count = weight[winner] (value before any same-cycle cfg write);
  - state -> SERVE.
- ARB otherwise: outputs are held with grant=0 and burst_done=0.
- SERVE: grant is held. end = (count == 1) OR (request[grant_idx] == 0). On the edge where end is true:
  - grant=0, grant_valid=0, burst_done=1 for one cycle;
  - ptr = (grant_idx+1) mod N;
  - state -> ARB.
- SERVE, end false: count decrements; all else held.
- Latency: request seen in ARB produces grant after 1 edge. There is exactly one idle ARB cycle between consecutive slices. A slice lasts min(weight, cycles until request drops) cycles, minimum 1.
- Early release: if the winner drops request in a granted cycle, grant stays high that cycle and clears on the next edge.
- enable=0 during SERVE does not shorten the slice. enable=0 in ARB blocks new grants; ptr is unchanged.
- cfg write: weight[cfg_idx] = cfg_weight on the next edge in any state, including write-to-0.
  - A write to the requester being served does not alter the running count.
  - A new weight applies from that requester's next slice.
- grant_idx keeps its last value while grant=0.
- burst_done is never asserted together with grant_valid for the same slice. It may coincide with a new grant only if N=1 (not supported).
- Count width is WW. Weight 2^WW-1 yields 15 granted cycles for WW=4; there is no overflow path.

Test Plan:
1. Reset release, weights default 1, request=8'b0000_0101 held:
   - grant=0000_0001 for 1 cycle, then 1 gap cycle with burst_done=1;
   - grant=0000_0100 for 1 cycle, gap, then 0000_0001 again;
   - period 4 cycles.
2. weight[0]=3, weight[1]=2, request=8'b0000_0011:
   - grant0 for 3 cycles, gap, grant1 for 2 cycles, gap;
   - repeat with period 7; burst_done pulses 2 per period.
3. weight[5]=0, request=8'b0010_0000: grant stays 0 and busy=0 indefinitely. Then write weight[5]=2: grant=0010_0000 for 2 cycles.
4. weight[3]=8, request[3] dropped after grant's 2nd cycle: grant falls after 3 granted cycles, burst_done=1, next search starts at ptr=4.
5. Mid-slice (weight=6, 2nd granted cycle), assert reset=0 asynchronously:
   - grant, grant_valid, burst_done go 0 without waiting for clk;
   - after release, ptr=0 and all weights read back as 1 via grant lengths.
6. enable=0 during a 4-cycle slice: slice completes all 4 cycles, burst_done pulses, then no grant until enable=1. Grant then goes to the next eligible after the previous winner.
